// File: rtl/apb_dp_mem_gen2.sv
// APB3/APB4 completer memory with programmable wait states, a write-protected window
// and a second native port (B) sharing the same array.
module apb_dp_mem_gen2 #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int READ_WAIT   = 1,
  parameter int WRITE_WAIT  = 3,
  parameter int RO_BASE     = 'h001,
  parameter int RO_LIMIT    = 'h00E,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  B_EN,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_WDATA,
  input  logic [STRB_WIDTH-1:0] B_BE,
  output logic [DATA_WIDTH-1:0] B_RDATA,
  output logic                  B_ERR,
  output logic                  B_COLL
);

  localparam int                  IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_B  = ADDR_WIDTH'(RO_BASE);
  localparam logic [ADDR_WIDTH-1:0] RO_L  = ADDR_WIDTH'(RO_LIMIT);
  localparam bit                  RO_EN   = (RO_LIMIT >= RO_BASE);
  localparam logic [7:0]          RW_C    = 8'(READ_WAIT);
  localparam logic [7:0]          WW_C    = 8'(WRITE_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_wcnt;
  logic                  w_p_oor;
  logic                  w_p_ro;
  logic                  w_p_err;
  logic                  w_pready;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_p_idx;
  logic                  w_b_oor;
  logic                  w_b_wr;
  logic [IDX_W-1:0]      w_b_idx;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic                  r_b_err;
  logic                  r_b_coll;

  assign w_p_oor  = {1'b0, PADDR} >= DEPTH_C;
  assign w_p_ro   = RO_EN && (PADDR >= RO_B) && (PADDR <= RO_L);
  assign w_p_err  = w_p_oor | (PWRITE & w_p_ro);
  assign w_p_idx  = PADDR[IDX_W-1:0];
  assign w_commit = w_pready & PWRITE & ~w_p_err;

  assign w_b_oor  = {1'b0, B_ADDR} >= DEPTH_C;
  assign w_b_wr   = B_EN & B_WE & ~w_b_oor;
  assign w_b_idx  = B_ADDR[IDX_W-1:0];

  // Errors bypass the wait counter so they complete on the first ACCESS cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pready    = 1'b0;
    case (r_state)
      S_IDLE:   if (PSEL && !PENABLE) w_state_nxt = S_SETUP;
      S_SETUP:  if (PSEL && PENABLE)  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        w_pready = (r_wcnt == 8'd0) || w_p_err;
        if (w_pready) w_state_nxt = PSEL ? S_SETUP : S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_wcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_SETUP && w_state_nxt == S_ACCESS)
        r_wcnt <= PWRITE ? WW_C : RW_C;
      else if (r_state == S_ACCESS && r_wcnt != 8'd0)
        r_wcnt <= r_wcnt - 8'd1;
    end
  end

  assign PREADY  = w_pready;
  assign PSLVERR = w_pready & w_p_err;
  assign PRDATA  = (w_pready && !PWRITE && !w_p_err) ? r_mem[w_p_idx] : '0;

  // APB lanes are assigned last so they win a same-word collision byte by byte.
  always_ff @(posedge PCLK) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (w_b_wr && B_BE[i])    r_mem[w_b_idx][8*i +: 8] <= B_WDATA[8*i +: 8];
      if (w_commit && PSTRB[i]) r_mem[w_p_idx][8*i +: 8] <= PWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_b_rdata <= '0;
      r_b_err   <= 1'b0;
      r_b_coll  <= 1'b0;
    end else begin
      r_b_err  <= B_EN & w_b_oor;
      r_b_coll <= w_commit & w_b_wr & (w_b_idx == w_p_idx);
      if (B_EN && (w_b_oor || !B_WE))
        r_b_rdata <= w_b_oor ? '0 : r_mem[w_b_idx];
    end
  end

  assign B_RDATA = r_b_rdata;
  assign B_ERR   = r_b_err;
  assign B_COLL  = r_b_coll;

endmodule
